mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-002 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request a multiply/divide; sampled at the rising clk edge
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  32  multiplicand or dividend (rs)
- b  in  32  multiplier or divisor (rt)
- mthi  in  1  write a into HI
- mtlo  in  1  write a into LO
- busy  out  1  operation in progress; the pipeline stalls MFHI/MFLO while high
- done  out  1  one-cycle pulse when HI/LO take a new result
- hi  out  32  HI register
- lo  out  32  LO register
REQ-003 All outputs SHALL be registered.

Function
REQ-004 States SHALL be IDLE, RUN and FIX.
- IDLE -> RUN on start=1.
- RUN -> FIX after 32 iterations.
- FIX -> IDLE after one cycle.
REQ-005 While busy=0, start=1 SHALL latch op, |a| and |b| into working registers, latch the result signs, clear the iteration counter, and enter RUN.
- Magnitude is taken for signed ops only.
- Unsigned ops use a and b as-is.
REQ-006 While busy=1, start SHALL be ignored.
REQ-007 RUN SHALL take exactly 32 cycles, one iteration per cycle, with a 5-bit counter running 0..31.
- Multiply: shift-add. Per cycle, add the multiplicand to the upper partial product when the current multiplier LSB is 1, then shift right 1; 64-bit product.
- Divide: restoring. Per cycle, shift the remainder:quotient pair left 1, trial-subtract the divisor using a 33-bit add, restore on a negative result, and set the quotient bit otherwise.
REQ-008 FIX SHALL load hi/lo in its cycle and pulse done=1 for that single cycle.
- Multiply: {hi,lo} = the 64-bit product, negated when the signs differ and the op is MULT.
- Divide: lo = quotient, hi = remainder.
- DIV quotient is negated when the operand signs differ.
- DIV remainder takes the sign of the dividend.
REQ-009 busy SHALL be 1 from the cycle after start is accepted through the FIX cycle: 33 cycles total.
- The first start is accepted at edge N.
- done is high in cycle N+33, and hi/lo show the result from edge N+33.
- busy=0 from N+34.
- A new start SHALL be accepted on the edge that leaves FIX, so back-to-back operations are possible.
REQ-010 Divide by zero SHALL produce lo=0xFFFFFFFF and hi=a (the dividend as latched), for both DIV and DIVU, with no exception.
REQ-011 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-012 mthi and mtlo SHALL write a into hi/lo on the next edge only while busy=0; while busy=1 they are ignored.
REQ-013 start together with mthi/mtlo while idle: both take effect; the move lands immediately and the operation result later overwrites hi/lo in FIX.
REQ-014 mthi and mtlo together SHALL write a into both registers.
REQ-015 hi and lo SHALL hold their value in every cycle not covered by REQ-008, REQ-012 or REQ-014.

Reset
REQ-016 rst=1 at a rising edge SHALL force:
- state to IDLE;
- busy=0, done=0;
- hi=0x00000000, lo=0x00000000;
- the counter and working registers to 0.
REQ-017 Reset SHALL have priority over start, mthi and mtlo. Reset in RUN or FIX SHALL abort the operation with no done pulse and no hi/lo update.

Verification
REQ-018 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 33 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001.
REQ-019 MULT a=0xFFFFFFFD (-3), b=0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-020 DIVU a=100, b=7 -> lo=14, hi=2. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-021 Start MULTU 3*4, then assert start with op=DIVU and mthi=1 (a=0xDEAD) during busy -> both ignored; hi=0, lo=12; exactly one done pulse.
REQ-022 Start MULTU, then assert rst at iteration 10 -> busy=0, hi=lo=0 the next cycle, and no done pulse. A subsequent start completes normally.
REQ-023 Back-to-back: a second start in the FIX cycle -> accepted; its done arrives exactly 33 cycles after the first done.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on operand magnitudes, one
// iteration per clock, followed by a sign-fixup cycle that loads HI/LO.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo writes allowed
// RUN   | 32 iterations of shift-add or restoring divide
// FIX   | sign fixup, HI/LO load, done pulse; may accept the next start
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [4:0]  cnt;
    logic [63:0] acc;      // {partial product | remainder, multiplier | quotient}
    logic [31:0] opnd;     // multiplicand magnitude or divisor magnitude
    logic [31:0] a_r;      // dividend as presented, returned in HI on divide by zero

    logic        in_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        accept;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [64:0] div_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes, one iteration step of each algorithm, and the sign fixup
    always_comb begin
        in_signed = ~op[0];
        abs_a     = (in_signed && a[31]) ? (~a + 32'd1) : a;
        abs_b     = (in_signed && b[31]) ? (~b + 32'd1) : b;
        accept    = start && ((state == IDLE) || (state == FIX));

        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};

        // 33-bit trial subtract; bit 32 set means the remainder went negative
        div_sh   = {acc, 1'b0};
        div_diff = div_sh[64:32] + {1'b1, ~opnd} + 33'd1;
        div_next = div_diff[32] ? div_sh[63:0] : {div_diff[31:0], div_sh[31:1], 1'b1};

        prod_fix = neg_q ? (~acc + 64'd1) : acc;
        quot_fix = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    // Controller FSM, datapath registers and HI/LO outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            a_r    <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi) hi <= a;
                    if (mtlo) lo <= a;
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= FIX;
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!is_div) begin
                        {hi, lo} <= prod_fix;
                    end else if (opnd == 32'd0) begin
                        hi <= a_r;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A new operation may start from IDLE or on the edge leaving FIX
            if (accept) begin
                state  <= RUN;
                busy   <= 1'b1;
                cnt    <= 5'd0;
                is_div <= op[1];
                neg_q  <= in_signed && (a[31] ^ b[31]);
                neg_r  <= in_signed && a[31];
                a_r    <= a;
                acc    <= op[1] ? {32'd0, abs_a} : {32'd0, abs_b};
                opnd   <= op[1] ? abs_b : abs_a;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus
// randomized operations compared against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level arithmetic on 64-bit values
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] h, output logic [31:0] l);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'(signed'(x));
        sy = longint'(signed'(y));
        case (o)
            2'd0: begin p = sx * sy; h = p[63:32]; l = p[31:0]; end
            2'd1: begin p = {32'd0, x} * {32'd0, y}; h = p[63:32]; l = p[31:0]; end
            2'd2: begin
                if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin q = sx / sy; r = sx % sy; h = r[31:0]; l = q[31:0]; end
            end
            default: begin
                if (y == 32'd0) begin h = x; l = 32'hFFFF_FFFF; end
                else begin h = x % y; l = x / y; end
            end
        endcase
    endfunction

    // Drive start for one edge; returns at the first falling edge after acceptance
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges from the launch edge until done; -1 on timeout
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 45) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] eh, el;
        int lat;
        model(o, x, y, eh, el);
        launch(o, x, y);
        chk({tag, "_busy"}, busy, 1'b1);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 34);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_idle"}, busy, 1'b0);
        @(negedge clk);
        chk({tag, "_pulse"}, done, 1'b0);
    endtask

    initial begin
        logic [31:0] eh, el, eh2, el2, x, y;
        logic [1:0]  o;
        int lat, dn;

        rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
        run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("divu_zero", 2'd3, 32'd5, 32'd0);
        run_op("div_zero_neg", 2'd2, 32'hFFFF_FF00, 32'd0);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", lo, 32'h8000_0000);
        chk("divu_const", {hi, lo}, {32'd0, 32'h8000_0000});

        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            if (i % 4 == 3) y = 32'd0;
            if (i % 3 == 1) y = 32'($urandom_range(1, 20));
            if (i % 5 == 2) x = 32'($urandom_range(0, 50));
            run_op("rand", o, x, y);
        end

        // Moves while idle, singly and together
        @(negedge clk); mthi = 1'b1; mtlo = 1'b1; a = 32'h1234_5678;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
        chk("mt_both_hi", hi, 32'h1234_5678);
        chk("mt_both_lo", lo, 32'h1234_5678);
        a = 32'hCAFE_0001; mthi = 1'b1;
        @(negedge clk); mthi = 1'b0; a = 32'h0;
        chk("mthi_hi", hi, 32'hCAFE_0001);
        chk("mthi_lo_hold", lo, 32'h1234_5678);
        @(negedge clk);
        chk("hold_hi", hi, 32'hCAFE_0001);

        // start together with mtlo: move lands now, result overwrites later
        start = 1'b1; op = 2'd1; a = 32'd7; b = 32'd9; mtlo = 1'b1;
        @(negedge clk); start = 1'b0; mtlo = 1'b0;
        chk("mv_start_lo", lo, 32'd7);
        wait_done(lat);
        chk("mv_start_lat", lat, 34);
        chk("mv_start_res", {hi, lo}, {32'd0, 32'd63});

        // start and mthi during busy are ignored
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        launch(2'd1, 32'd3, 32'd4);
        start = 1'b1; op = 2'd3; a = 32'hDEAD; b = 32'd1; mthi = 1'b1;
        @(negedge clk); start = 1'b0; mthi = 1'b0;
        chk("busy_mthi_hi", hi, 32'd0);
        dn = 0;
        for (int k = 0; k < 80; k++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        chk("busy_ign_dones", dn, 1);
        chk("busy_ign_res", {hi, lo}, {32'd0, 32'd12});
        chk("busy_ign_idle", busy, 1'b0);

        // Reset during RUN aborts
        launch(2'd1, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1) dn++;
            @(negedge clk);
        end
        chk("abort_nodone", dn, 0);
        run_op("after_abort", 2'd0, 32'hFFFF_FFF0, 32'h0000_0100);

        // Back-to-back: second start in FIX
        model(2'd3, 32'd1000, 32'd33, eh, el);
        model(2'd0, 32'h8000_0000, 32'h8000_0000, eh2, el2);
        launch(2'd3, 32'd1000, 32'd33);
        repeat (32) @(negedge clk);
        chk("b2b_fix_busy", {done, busy}, 2'b01);
        start = 1'b1; op = 2'd0; a = 32'h8000_0000; b = 32'h8000_0000;
        @(negedge clk); start = 1'b0;
        chk("b2b_done1", done, 1'b1);
        chk("b2b_res1", {hi, lo}, {eh, el});
        chk("b2b_busy2", busy, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done !== 1'b1 && lat < 45);
        chk("b2b_gap", lat, 33);
        chk("b2b_res2", {hi, lo}, {eh2, el2});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
